polyveck_pointwise_poly_montgomery: RTL and testbench

- Downstream neighbour of the K-polynomial forward-NTT stage.
- Takes the NTT-domain vector v (K polys × 256 signed 32-bit coeffs) and one NTT-domain polynomial c (e.g. c_hat).
- Computes out[k][i] = montgomery_reduce(int64(c[i]) * int64(v[k][i])) for all k, i.
- Processes LANES coefficients per cycle through a pipelined reducer. Output feeds the inverse NTT stage.

---
 rtl/polyveck_pointwise_poly_montgomery_pkg.sv | 28 ++
 rtl/polyveck_pointwise_poly_montgomery_mrpipe.sv | 66 ++++++
 rtl/polyveck_pointwise_poly_montgomery.sv | 116 +++++++++++
 tb/tb_polyveck_pointwise_poly_montgomery.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/polyveck_pointwise_poly_montgomery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : polyveck_pointwise_poly_montgomery_pkg
// Brief    : Shared Dilithium constants and FSM encoding for the pointwise
//            Montgomery multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package polyveck_pointwise_poly_montgomery_pkg;

    localparam int K      = 6;
    localparam int N      = 256;
    localparam int LANES  = 8;
    localparam int MR_LAT = 3;
    localparam int CW     = 32;
    localparam int PW     = 64;
    localparam int Q      = 8380417;
    localparam int QINV   = 58728449;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/polyveck_pointwise_poly_montgomery_mrpipe.sv
`default_nettype none
// ============================================================================
// Module   : polyveck_pointwise_poly_montgomery_mrpipe
// Brief    : One lane: 32x32 signed product followed by a 3-stage Montgomery
//            reduction with valid tracking.
// Revision : 1.0 - initial release
// ============================================================================
module polyveck_pointwise_poly_montgomery_mrpipe
    import polyveck_pointwise_poly_montgomery_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic signed [CW-1:0] i_a,
    input  logic signed [CW-1:0] i_b,
    output logic                 o_valid,
    output logic signed [CW-1:0] o_r
);

    localparam logic [CW-1:0]        c_QINV = CW'(QINV);
    localparam logic signed [PW-1:0] c_Q64  = PW'(Q);

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] r_a1;
    logic signed [PW-1:0] r_a2;
    logic        [CW-1:0] w_t;
    logic        [CW-1:0] r_t2;
    logic signed [PW-1:0] w_tq;
    logic signed [PW-1:0] w_d;
    logic        [CW-1:0] w_unused_lo;
    logic signed [CW-1:0] r_r3;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;

    assign w_a  = $signed({{CW{i_a[CW-1]}}, i_a}) * $signed({{CW{i_b[CW-1]}}, i_b});
    assign w_t  = r_a1[CW-1:0] * c_QINV;
    assign w_tq = $signed({{CW{r_t2[CW-1]}}, r_t2}) * c_Q64;
    // Low half of the difference is zero by construction of t.
    assign w_d  = r_a2 - w_tq;
    assign w_unused_lo = w_d[CW-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge i_clk) begin
        r_a1 <= w_a;
        r_a2 <= r_a1;
        r_t2 <= w_t;
        r_r3 <= w_d[PW-1:CW];
    end

    assign o_valid = r_v3;
    assign o_r     = r_r3;

endmodule
`default_nettype wire

// File: rtl/polyveck_pointwise_poly_montgomery.sv
`default_nettype none
// ============================================================================
// Module   : polyveck_pointwise_poly_montgomery
// Brief    : out[k][i] = montgomery_reduce(c[i] * v[k][i]), LANES coeffs/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module polyveck_pointwise_poly_montgomery
    import polyveck_pointwise_poly_montgomery_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic signed [K*N*CW-1:0]    i_v_in,
    input  logic signed [N*CW-1:0]      i_c_in,
    output logic signed [K*N*CW-1:0]    o_v_out,
    output logic                        o_done
);

    localparam int BPP    = N / LANES;
    localparam int BEATS  = K * N / LANES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int DRN_W  = $clog2(MR_LAT + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [BEAT_W-1:0]   r_beat;
    logic [DRN_W-1:0]    r_drain;
    logic [K*N*CW-1:0]   r_v;
    logic [N*CW-1:0]     r_c;
    logic [K*N*CW-1:0]   r_vout;
    logic [BEAT_W-1:0]   r_tag [MR_LAT];
    logic                w_issue;
    logic [LANES-1:0]    w_pv;
    logic [CW-1:0]       w_pr [LANES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_RUN;
            S_RUN:   if (r_beat == BEAT_W'(BEATS - 1)) w_state_next = S_DRAIN;
            // Stay until the last lane has exited the pipe and been written back.
            S_DRAIN: if (r_drain == DRN_W'(MR_LAT)) w_state_next = S_DONE;
            S_DONE:  if (!i_start) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat  <= '0;
            r_drain <= '0;
        end else begin
            if (r_state == S_LOAD)      r_beat <= '0;
            else if (r_state == S_RUN)  r_beat <= r_beat + 1'b1;
            if (r_state == S_RUN)       r_drain <= '0;
            else if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD) begin
            r_v <= i_v_in;
            r_c <= i_c_in;
        end
    end

    // Beat index travels alongside the reducer so write-back knows its slot.
    always_ff @(posedge i_clk) begin
        r_tag[0] <= r_beat;
        for (int s = 1; s < MR_LAT; s++) r_tag[s] <= r_tag[s-1];
    end

    assign w_issue = (r_state == S_RUN);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [CW-1:0] w_vop;
        logic signed [CW-1:0] w_cop;
        logic signed [CW-1:0] w_r;

        assign w_vop = r_v[(int'(r_beat) * LANES + j) * CW +: CW];
        assign w_cop = r_c[((int'(r_beat) % BPP) * LANES + j) * CW +: CW];

        polyveck_pointwise_poly_montgomery_mrpipe u_mr (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_valid (w_issue),
            .i_a     (w_cop),
            .i_b     (w_vop),
            .o_valid (w_pv[j]),
            .o_r     (w_r)
        );

        assign w_pr[j] = w_r;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vout <= '0;
        end else begin
            for (int j = 0; j < LANES; j++) begin
                if (w_pv[j]) r_vout[(int'(r_tag[MR_LAT-1]) * LANES + j) * CW +: CW] <= w_pr[j];
            end
        end
    end

    assign o_v_out = r_vout;
    assign o_done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_polyveck_pointwise_poly_montgomery.sv
`default_nettype none
// ============================================================================
// Module   : tb_polyveck_pointwise_poly_montgomery
// Brief    : Directed + random bench with a reference Montgomery model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_polyveck_pointwise_poly_montgomery;
    import polyveck_pointwise_poly_montgomery_pkg::*;

    localparam int  NC   = K * N;
    localparam int  R2   = 4193792;
    localparam int  DONE_CYC = 197;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    logic signed [NC*CW-1:0]   v_in;
    logic signed [N*CW-1:0]    c_in;
    logic signed [NC*CW-1:0]   v_out;
    logic                      done;

    int  vm [NC];
    int  cm [N];
    int  exp_q [NC];
    int  checks;
    int  failures;
    bit  chk_en;
    int  cyc;

    polyveck_pointwise_poly_montgomery dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_v_in  (v_in),
        .i_c_in  (c_in),
        .o_v_out (v_out),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mont_mul(input int c, input int v);
        longint a;
        int     t;
        a = longint'(c) * longint'(v);
        t = int'(a * longint'(QINV));
        return int'((a - longint'(t) * longint'(Q)) >>> 32);
    endfunction

    function automatic int rnd_coef();
        return int'($urandom_range(0, 2 * Q - 2)) - (Q - 1);
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NC; i++) begin
            v_in[i*CW +: CW] = vm[i];
            exp_q[i] = mont_mul(cm[i % N], vm[i]);
        end
        for (int i = 0; i < N; i++) c_in[i*CW +: CW] = cm[i];
    endtask

    // Full result compared on every cycle done is high.
    always @(negedge clk) begin
        if (chk_en && rst_n && done) begin
            int bad;
            bad = -1;
            for (int i = 0; i < NC; i++)
                if (bad < 0 && int'(v_out[i*CW +: CW]) != exp_q[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL v_out[%0d]: got %0d expected %0d", bad,
                         int'(v_out[bad*CW +: CW]), exp_q[bad]);
            end
        end
    end

    // Called #1 after an edge; the next edge is cycle 0.
    task automatic run_op(input bit perturb);
        start = 1'b1;
        cyc = -1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (perturb && cyc == 1) begin
                for (int i = 0; i < NC; i++) v_in[i*CW +: CW] = $urandom;
                for (int i = 0; i < N; i++)  c_in[i*CW +: CW] = $urandom;
            end
        end while (!done && cyc < 400);
        check_int("done_cycle", cyc, DONE_CYC);
    endtask

    task automatic drop_start();
        start = 1'b0;
        check_int("done_before_drop_edge", int'(done), 1);
        @(posedge clk); #1;
        check_int("done_after_drop", int'(done), 0);
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        rst_n = 1'b0; start = 1'b0; v_in = '0; c_in = '0;

        check_int("model_identity5",  mont_mul(R2, 5), 5);
        check_int("model_minus1",     mont_mul(R2, -1), -1);
        check_int("model_2p32x3",     mont_mul(65536, 196608), 3);
        check_int("model_neg2p32x3",  mont_mul(-65536, 196608), -3);

        repeat (3) @(posedge clk);
        #1;
        check_int("reset_done", int'(done), 0);
        check_int("reset_vout_zero", int'(v_out == '0), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("idle_done", int'(done), 0);
        chk_en = 1'b1;

        // Identity
        for (int i = 0; i < NC; i++) vm[i] = i;
        for (int i = 0; i < N; i++)  cm[i] = R2;
        apply_inputs();
        run_op(1'b0);
        check_int("identity_coef1535", int'(v_out[1535*CW +: CW]), 1535);
        check_int("identity_coef300",  int'(v_out[300*CW +: CW]), 300);
        drop_start();

        // Sign
        for (int i = 0; i < NC; i++) vm[i] = -1;
        apply_inputs();
        run_op(1'b0);
        check_int("sign_coef7", int'(v_out[7*CW +: CW]), -1);
        drop_start();

        // Zero c, hold start for 50 extra cycles
        for (int i = 0; i < NC; i++) vm[i] = int'($urandom);
        for (int i = 0; i < N; i++)  cm[i] = 0;
        apply_inputs();
        run_op(1'b0);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            check_int("zero_done_held", int'(done), 1);
        end
        check_int("zero_coef0", int'(v_out[0 +: CW]), 0);
        drop_start();

        // Random, with input perturbation after LOAD
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NC; i++) vm[i] = rnd_coef();
            for (int i = 0; i < N; i++)  cm[i] = rnd_coef();
            apply_inputs();
            run_op(1'b1);
            drop_start();
        end

        // Reset in the middle of RUN
        for (int i = 0; i < NC; i++) vm[i] = i;
        for (int i = 0; i < N; i++)  cm[i] = R2;
        apply_inputs();
        start = 1'b1;
        cyc = -1;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (cyc < 101);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_int("midrst_done", int'(done), 0);
        check_int("midrst_vout_zero", int'(v_out == '0), 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) vm[i] = rnd_coef();
        for (int i = 0; i < N; i++)  cm[i] = rnd_coef();
        apply_inputs();
        run_op(1'b0);
        drop_start();

        // Back-to-back with a one-cycle start gap
        for (int i = 0; i < NC; i++) vm[i] = -i;
        for (int i = 0; i < N; i++)  cm[i] = R2;
        apply_inputs();
        run_op(1'b0);
        check_int("b2b_coef1000", int'(v_out[1000*CW +: CW]), -1000);
        drop_start();

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
